reaction_display: RTL

REACTION_DISPLAY -- requirements
Module: reaction_display

---
 rtl/reaction_display.sv | 104 ++++++++++
 1 files changed

// File: rtl/reaction_display.sv
// reaction_display: converts a binary ms value to BCD with a double-dabble FSM and
// scans four active-low 7-segment digits, with an alternative "HI" greeting.
module reaction_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [13:0] i_display_val,
    input  logic        i_display_greeting,
    output logic [3:0]  o_an,
    output logic [7:0]  o_sseg,
    output logic        o_bcd_ready
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = 1;

    state_t state;
    logic [13:0] val_clamp, last_val, bin;
    logic [15:0] bcd, bcd_adj, disp;
    logic [3:0] cnt, nib;
    logic primed, blank;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0] d;
    logic [7:0] dig, seg;

    assign val_clamp = i_display_val > 14'd9999 ? 14'd9999 : i_display_val;

    for (genvar n = 0; n < 4; n++) begin : g_adj
        assign bcd_adj[4*n +: 4] = bcd[4*n +: 4] >= 4'd5 ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            primed      <= 1'b0;
            last_val    <= '0;
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            disp        <= '0;
            o_bcd_ready <= 1'b0;
        end else begin
            o_bcd_ready <= 1'b0;
            case (state)
                IDLE: if (!primed || val_clamp != last_val) begin
                    primed   <= 1'b1;
                    last_val <= val_clamp;
                    bin      <= val_clamp;
                    bcd      <= '0;
                    cnt      <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
                    cnt        <= cnt + 4'd1;
                    state      <= cnt == 4'd13 ? DONE : SHIFT;
                end
                DONE: begin
                    disp        <= bcd;
                    o_bcd_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign d   = refresh[REFRESH_BITS-1 -: 2];
    assign nib = disp[{d, 2'b00} +: 4];

    // Leading-zero blanking: a digit is blank when it and every digit left of it are zero
    always_comb begin
        blank = d == 2'd3 ? disp[15:12] == 4'd0 :
                d == 2'd2 ? disp[15:8] == 8'd0 :
                d == 2'd1 ? disp[15:4] == 12'd0 : 1'b0;
        case (nib)
            4'd0:    dig = 8'hC0;
            4'd1:    dig = 8'hF9;
            4'd2:    dig = 8'hA4;
            4'd3:    dig = 8'hB0;
            4'd4:    dig = 8'h99;
            4'd5:    dig = 8'h92;
            4'd6:    dig = 8'h82;
            4'd7:    dig = 8'hF8;
            4'd8:    dig = 8'h80;
            4'd9:    dig = 8'h90;
            default: dig = 8'hFF;
        endcase
        seg = i_display_greeting ? (d == 2'd1 ? 8'h89 : d == 2'd0 ? 8'hF9 : 8'hFF) :
              blank ? 8'hFF : dig;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            refresh <= '0;
            o_an    <= 4'hF;
            o_sseg  <= 8'hFF;
        end else begin
            refresh <= refresh + REFRESH_ONE;
            o_an    <= ~(4'b0001 << d);
            o_sseg  <= seg;
        end
    end
endmodule
